// File: rtl/led_pkg.sv
// led_pkg: shared state encoding and constants for the LED arbiter.
package led_pkg;
  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_e;
  localparam int LED_W = 8;
  localparam int DEF_DWELL = 25000000;
endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running 8-bit PWM gate that registers the masked LED pattern.
module led_pwm import led_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       brightness,
  input  logic [LED_W-1:0] in,
  output logic [LED_W-1:0] out
);
  logic [7:0]       cnt_q, cnt_d;
  logic [LED_W-1:0] out_q, out_d;
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    out_d = in & {LED_W{cnt_q < brightness}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
endmodule

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin time-sliced sharing of 8 LEDs between NUM_REQ requesters.
// Define LED_ARBITER_PWM_EN to add global brightness PWM on the LED output.
module led_arbiter import led_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = DEF_DWELL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LED_W*NUM_REQ-1:0] pattern,
  input  logic [7:0]               brightness,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         led,
  output logic                     busy
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES);
  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d, win, idx;
  logic                 win_ok, own_req, others, expired;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, own_oh;
  logic [LED_W-1:0]     led_d;
  // Descending offsets so the closest requester after the owner wins last.
  always_comb begin
    idx = '0;
    win = owner_q;
    win_ok = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(owner_q) + k) % NUM_REQ);
      if (req[idx]) begin
        win = idx;
        win_ok = 1'b1;
      end
    end
  end
  always_comb begin
    own_oh  = NUM_REQ'(1) << owner_q;
    own_req = req[owner_q];
    others  = |(req & ~own_oh);
    expired = cnt_q == CW'(DWELL_CYCLES - 1);
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        state_d = win_ok ? OWN : IDLE;
        owner_d = win_ok ? win : owner_q;
      end
      OWN: begin
        if (!own_req) state_d = others ? SWITCH : IDLE;
        else if (expired && others) state_d = SWITCH;
      end
      SWITCH: begin
        state_d = win_ok ? OWN : IDLE;
        owner_d = win_ok ? win : owner_q;
      end
      default: state_d = IDLE;
    endcase
    cnt_d   = (state_q == OWN && state_d == OWN && !expired) ? cnt_q + 1'b1 : '0;
    grant_d = (state_d == OWN) ? NUM_REQ'(1) << owner_d : '0;
    led_d   = (state_q == OWN && state_d == OWN) ? pattern[int'(owner_q)*LED_W +: LED_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end
  assign grant = grant_q;
  assign busy  = state_q != IDLE;
`ifdef LED_ARBITER_PWM_EN
  led_pwm u_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (brightness),
    .in         (led_d),
    .out        (led)
  );
`else
  logic [LED_W-1:0] led_q;
  logic             unused_brightness;
  assign unused_brightness = ^brightness;
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else led_q <= led_d;
  end
  assign led = led_q;
`endif
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed self-checking bench for led_arbiter (NUM_REQ=4, DWELL_CYCLES=8).
module tb_led_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pattern = '0;
  logic [7:0]  brightness = 8'd255;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        busy;
  int errors = 0;
  int checks = 0;

  led_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .pattern(pattern),
    .brightness(brightness), .grant(grant), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pattern = {8'h11, 8'h22, 8'h33, 8'hA5};
    rst = 1'b1;
    tick();
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got=%h exp=00", led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got=%b exp=0001", grant); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL first_led_lag got=%h exp=00", led); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%b exp=1", busy); end
    tick();
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL first_led got=%h exp=a5", led); end
    pattern[7:0] = 8'h3C;
    tick();
    checks++; if (led !== 8'h3C) begin errors++; $display("FAIL pattern_follow got=%h exp=3c", led); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] el;
    do_reset();
    pattern = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b0101;
    for (int c = 0; c <= 18; c++) begin
      tick();
      eg = (c < 8) ? 4'b0001 : (c == 8) ? 4'b0000 : (c < 17) ? 4'b0100 : (c == 17) ? 4'b0000 : 4'b0001;
      el = (c >= 1 && c < 8) ? 8'h01 : (c >= 10 && c < 17) ? 8'h04 : 8'h00;
      checks++; if (grant !== eg) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, eg); end
      checks++; if (led !== el) begin errors++; $display("FAIL rr_led c=%0d got=%h exp=%h", c, led, el); end
    end
  endtask

  task automatic test_sole_owner();
    do_reset();
    pattern = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL sole_first got=%b exp=0010", grant); end
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++; if (grant !== 4'b0010 || led !== 8'h02) begin errors++; $display("FAIL sole_hold c=%0d grant=%b led=%h exp 0010/02", c, grant, led); end
    end
  endtask

  task automatic test_nonowner();
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    req = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL nonowner_hold c=%0d got=%b exp=0001", c, grant); end
    end
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL nonowner_switch grant=%b busy=%b exp 0000/1", grant, busy); end
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL nonowner_next got=%b exp=0010", grant); end
  endtask

  task automatic test_drop_at_expiry();
    do_reset();
    pattern = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b0001;
    for (int c = 0; c < 8; c++) tick();
    req = 4'b1000;
    tick();
    checks++; if (grant !== 4'b0000 || led !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL drop_switch grant=%b led=%h busy=%b exp 0000/00/1", grant, led, busy); end
    tick();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_next got=%b exp=1000", grant); end
    tick();
    checks++; if (led !== 8'h08) begin errors++; $display("FAIL drop_led got=%h exp=08", led); end
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) tick();
    req = 4'b0000;
    tick();
    checks++; if (grant !== 4'b0000 || led !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle grant=%b led=%h busy=%b exp 0000/00/0", grant, led, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (grant !== 4'b0000 || led !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset grant=%b led=%h busy=%b exp 0000/00/0", grant, led, busy); end
    rst = 1'b0;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_regrant got=%b exp=0001", grant); end
  endtask

`ifdef LED_ARBITER_PWM_EN
  task automatic test_pwm();
    int on;
    do_reset();
    pattern = {8'h00, 8'h00, 8'h00, 8'hFF};
    brightness = 8'd64;
    req = 4'b0001;
    tick();
    tick();
    on = 0;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (led === 8'hFF) on++;
      else if (led !== 8'h00) begin checks++; errors++; $display("FAIL pwm_value got=%h exp=ff or 00", led); end
    end
    checks++; if (on !== 64) begin errors++; $display("FAIL pwm_64 on=%0d exp=64", on); end
    brightness = 8'd0;
    tick();
    on = 0;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (led !== 8'h00) on++;
    end
    checks++; if (on !== 0) begin errors++; $display("FAIL pwm_zero on=%0d exp=0", on); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_sole_owner();
    test_nonowner();
    test_drop_at_expiry();
    test_reset_mid();
`ifdef LED_ARBITER_PWM_EN
    test_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the 8 onboard LEDs (2..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 25000000: maximum ownership slice in clk cycles, 0.5 s at 50 MHz; legal range >= 2.
REQ-003 SHALL have port clk  input  1: 50 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset, driven as ~rst_n by the top level.
REQ-005 SHALL have port req  input  NUM_REQ: per-requester level request; bit i means requester i wants the LEDs.
REQ-006 SHALL have port pattern  input  8*NUM_REQ: LED pattern of requester i in bits [8i+7:8i].
REQ-007 SHALL have port brightness  input  8: global PWM duty; present in every build, used only when PWM is compiled in.
REQ-008 SHALL have port grant  output  NUM_REQ: registered one-hot ownership, or all zero.
REQ-009 SHALL have port led  output  8: registered LED drive.
REQ-010 SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement three states: IDLE, OWN and SWITCH.
REQ-012 In IDLE with any req bit high, the block SHALL pick the first requesting index at or after (last_owner+1) mod NUM_REQ, searching round-robin; grant and state OWN SHALL be registered on the next edge, giving 1-cycle latency.
REQ-013 In OWN, led SHALL equal pattern[owner], registered, with 1-cycle latency from any pattern change.
REQ-014 In OWN, a dwell counter SHALL increment every cycle, starting from 0 on entry to OWN.
REQ-015 In OWN, if req[owner] falls, the next state SHALL be SWITCH if any other req is high, else IDLE; this rule takes priority over dwell expiry in the same cycle.
REQ-016 In OWN, at counter == DWELL_CYCLES-1 with req[owner] still high: go to SWITCH if any other req is high; otherwise keep ownership, clear the counter, and do not blank the LEDs.
REQ-017 Requests from non-owners during OWN SHALL have no effect until the slice ends.
REQ-018 SWITCH SHALL last exactly 1 cycle with grant=0 and led=0, then grant the round-robin winner from owner+1 and enter OWN; if no request remains, enter IDLE.
REQ-019 In IDLE, grant SHALL be 0 and led SHALL be 0.
REQ-020 last_owner SHALL update only when a grant is issued.
REQ-021 Counter width SHALL be $clog2(DWELL_CYCLES), and the counter SHALL never wrap past DWELL_CYCLES-1.

Reset
REQ-022 On rst high at a clock edge, in any state including mid-slice: state=IDLE, grant=0, led=0, busy=0, counter=0, last_owner=NUM_REQ-1 (so requester 0 wins first), PWM counter=0.
REQ-023 The first grant after reset release SHALL occur no earlier than 1 cycle after rst falls.

Configuration
REQ-024 Macro LED_ARBITER_PWM_EN, when defined, SHALL add a free-running 8-bit PWM counter, and led SHALL be the arbitrated pattern AND {8{pwm_cnt < brightness}}: brightness 0 gives all LEDs off; 255 gives on 255 of every 256 cycles.
REQ-025 Without LED_ARBITER_PWM_EN, brightness SHALL be ignored, no PWM logic SHALL exist, and led SHALL be the arbitrated pattern directly.

Structure
REQ-026 Package led_pkg SHALL hold the state encoding (IDLE, OWN, SWITCH), LED_W=8, and the default dwell constant.
REQ-027 The PWM SHALL be sub-module led_pwm (clk, rst, brightness, in[7:0], out[7:0]), instantiated only under LED_ARBITER_PWM_EN; round-robin pick and FSM stay inline.

Verification
Common setup: NUM_REQ=4 and DWELL_CYCLES=8 unless stated.
REQ-028 Reset release, req=4'b0001, pattern0=8'hA5 -> grant=0001 one cycle later; led=8'hA5 one cycle after that; busy=1.
REQ-029 req=4'b0101 held -> requester 0 owns 8 cycles, 1 blank cycle (led=0, grant=0), requester 2 owns 8 cycles, blank, back to requester 0.
REQ-030 Sole requester 1 held for 30 cycles -> grant stays 0010 throughout and led never blanks at slice boundaries.
REQ-031 Owner 0 drops req in the same cycle its counter reaches 7 while req3 is high -> SWITCH then grant=1000; a case with no other requester -> IDLE, led=0.
REQ-032 rst pulsed for 1 cycle mid-slice -> next edge gives grant=0, led=0, busy=0; with req=1111 the following grant is 0001.
REQ-033 With LED_ARBITER_PWM_EN, pattern 8'hFF, brightness=64 -> led=8'hFF for exactly 64 of each 256 cycles; brightness=0 -> led=0 always.
